// File: rtl/q_transpose_pkg.sv
// q_transpose_pkg: element format constants and the column-major read order for a 3x3 matrix
package q_transpose_pkg;
  localparam int WORDLEN = 16;
  localparam int FRACTION_WIDTH = 12;
  localparam int MATRIX_ELEMENT_NUM = 9;
  localparam logic [8:0][3:0] T_LUT = '{4'd8, 4'd5, 4'd2, 4'd7, 4'd4, 4'd1, 4'd6, 4'd3, 4'd0};
endpackage

// File: rtl/q_transpose_if.sv
// q_transpose_if: pair-write and transposed-read stream signals between the rotation stage and q_transpose
interface q_transpose_if;
  import q_transpose_pkg::*;
  logic [WORDLEN-1:0] rot_out1_opr1;
  logic [WORDLEN-1:0] rot_out1_opr2;
  logic valid_transpose;
  logic start_transpose;
  logic [WORDLEN-1:0] transpose_out;
  modport master (output rot_out1_opr1, rot_out1_opr2, valid_transpose, start_transpose, input transpose_out);
  modport slave (input rot_out1_opr1, rot_out1_opr2, valid_transpose, start_transpose, output transpose_out);
endinterface

// File: rtl/q_transpose_mem.sv
// q_transpose_mem: 9-entry register file with a pair write port, write-pointer wrap and one async read port
module q_transpose_mem
  import q_transpose_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [3:0] waddr,
  input  logic [WORDLEN-1:0] wd1,
  input  logic [WORDLEN-1:0] wd2,
  output logic [3:0] waddr_nxt,
  input  logic [3:0] raddr,
  output logic [WORDLEN-1:0] rdata
);
  logic [WORDLEN-1:0] mem [MATRIX_ELEMENT_NUM];
  logic [4:0] sum;
  // next pointer skips two slots, restarting at 0 once it runs past the last entry
  always_comb begin
    sum = {1'b0, waddr} + 5'd2;
    waddr_nxt = (sum >= 5'd9) ? 4'd0 : sum[3:0];
  end
  // pair write; the second element is dropped when the first lands in the last slot
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MATRIX_ELEMENT_NUM; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wd1;
      if (waddr < 4'd8) mem[waddr + 4'd1] <= wd2;
    end
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/q_transpose.sv
// q_transpose: buffers Q row-major and streams Q^T column-major, one registered element per start cycle
module q_transpose
  import q_transpose_pkg::*;
(
  input logic CLK,
  input logic RST_n,
  q_transpose_if.slave bus
);
  logic [3:0] wptr;
  logic [3:0] wptr_nxt;
  logic [3:0] rcnt;
  logic [WORDLEN-1:0] rdata;
  q_transpose_mem u_mem (
    .clk(CLK),
    .rst(RST_n),
    .we(bus.valid_transpose),
    .waddr(wptr),
    .wd1(bus.rot_out1_opr1),
    .wd2(bus.rot_out1_opr2),
    .waddr_nxt(wptr_nxt),
    .raddr(T_LUT[rcnt]),
    .rdata(rdata)
  );
  // pointer/counter update and registered output; reads see pre-write contents
  always_ff @(posedge CLK) begin
    if (RST_n) begin
      wptr <= '0;
      rcnt <= '0;
      bus.transpose_out <= '0;
    end else begin
      if (bus.valid_transpose) wptr <= wptr_nxt;
      rcnt <= bus.start_transpose ? ((rcnt == 4'd8) ? 4'd0 : rcnt + 4'd1) : 4'd0;
      bus.transpose_out <= bus.start_transpose ? rdata : '0;
    end
  end
endmodule

// File: tb/tb_q_transpose.sv
// tb_q_transpose: directed vectors for pair writes, transposed streaming, abort, overlap and reset
module tb_q_transpose;
  logic CLK = 1'b0;
  logic RST_n = 1'b1;
  int n_pass = 0;
  int n_total = 0;
  logic [15:0] exp_q [9];
  q_transpose_if bus();
  q_transpose dut (.CLK(CLK), .RST_n(RST_n), .bus(bus.slave));
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_pair(input logic [15:0] a, input logic [15:0] b);
    bus.valid_transpose = 1'b1;
    bus.rot_out1_opr1 = a;
    bus.rot_out1_opr2 = b;
    tick();
    bus.valid_transpose = 1'b0;
  endtask

  task automatic stream(input string tag, input int n);
    bus.start_transpose = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("%s[%0d]", tag, k), bus.transpose_out, exp_q[k % 9]);
    end
    bus.start_transpose = 1'b0;
    tick();
    check({tag, "_idle"}, bus.transpose_out, 16'h0000);
  endtask

  task automatic do_reset();
    RST_n = 1'b1;
    tick();
    RST_n = 1'b0;
  endtask

  initial begin
    bus.valid_transpose = 1'b0;
    bus.start_transpose = 1'b0;
    bus.rot_out1_opr1 = '0;
    bus.rot_out1_opr2 = '0;
    tick();
    do_reset();
    check("reset_out", bus.transpose_out, 16'h0000);
    exp_q = '{default: 16'h0000};
    stream("zeros", 9);

    write_pair(16'h04cd, 16'h0333);
    write_pair(16'h0666, 16'h0b33);
    write_pair(16'h0400, 16'h0a66);
    exp_q = '{16'h04cd, 16'h0b33, 16'h0000, 16'h0333, 16'h0400, 16'h0000, 16'h0666, 16'h0a66, 16'h0000};
    stream("three", 9);

    do_reset();
    for (int p = 0; p < 5; p++) write_pair(16'(2 * p + 1), 16'(2 * p + 2));
    exp_q = '{16'd1, 16'd4, 16'd7, 16'd2, 16'd5, 16'd8, 16'd3, 16'd6, 16'd9};
    stream("full", 11);

    stream("abort_a", 4);
    tick();
    check("abort_low", bus.transpose_out, 16'h0000);
    stream("abort_b", 9);

    bus.valid_transpose = 1'b1;
    bus.rot_out1_opr1 = 16'h0011;
    bus.rot_out1_opr2 = 16'h0022;
    bus.start_transpose = 1'b1;
    tick();
    bus.valid_transpose = 1'b0;
    check("simul_first", bus.transpose_out, 16'd1);
    exp_q = '{16'h0011, 16'd4, 16'd7, 16'h0022, 16'd5, 16'd8, 16'd3, 16'd6, 16'd9};
    for (int k = 1; k < 9; k++) begin
      tick();
      check($sformatf("simul[%0d]", k), bus.transpose_out, exp_q[k]);
    end
    bus.start_transpose = 1'b0;
    tick();
    stream("simul_next", 9);

    bus.start_transpose = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("midrst[%0d]", k), bus.transpose_out, exp_q[k]);
    end
    RST_n = 1'b1;
    tick();
    check("midrst_out", bus.transpose_out, 16'h0000);
    RST_n = 1'b0;
    bus.start_transpose = 1'b0;
    tick();
    exp_q = '{default: 16'h0000};
    stream("after_rst", 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/q_transpose.md
# q_transpose

Buffers the 3x3 orthogonal matrix Q produced by the Givens-rotation stage of the QR-based matrix-inversion datapath. Elements arrive two per valid pulse in row-major order. On request, the block streams Q^T out one element per clock, feeding the back-substitution / multiply stage. Data is fixed-point (Q-format with FRACTION_WIDTH fractional bits) and is passed through unmodified.

## Interface
- WORDLEN, 16, element width in bits.
- MATRIX_ELEMENT_NUM, 9, number of matrix elements (3x3). Only the value 9 is supported.
- FRACTION_WIDTH, 12, fractional bits of the element format. Informational only; no arithmetic is performed.

Ports:
- CLK  in  1  the single clock; all logic is on the rising edge.
- RST_n  in  1  synchronous, active-high reset. The legacy name is kept; the `_n` suffix does not imply active-low.
- rot_out1_opr1  in  WORDLEN  first element of the incoming pair.
- rot_out1_opr2  in  WORDLEN  second element of the incoming pair.
- valid_transpose  in  1  write strobe for the pair, one pulse per pair.
- start_transpose  in  1  level; each cycle it is high, one transposed element is read.
- transpose_out  out  WORDLEN  registered output element.

## Operation
- Storage: 9 x WORDLEN registers mem[0..8], holding Q in row-major order (index = 3*row + col).
- Write pointer wptr is 4 bits, range 0..8.
- On a cycle with valid_transpose=1:
  - mem[wptr] <= opr1.
  - If wptr < 8: mem[wptr+1] <= opr2 and wptr <= wptr+2. If the result is >= 9, wptr wraps to 0.
  - If wptr == 8: only opr1 is stored, opr2 is dropped, and wptr <= 0.
- Read counter rcnt runs 0..8.
- On a cycle with start_transpose=1:
  - transpose_out <= mem[T(rcnt)], where T = {0,3,6,1,4,7,2,5,8}, i.e. column-major order.
  - rcnt increments and wraps from 8 to 0.
- On a cycle with start_transpose=0: rcnt <= 0 and transpose_out <= 0.
- Deasserting start mid-stream aborts the stream. The next assertion restarts at element 0.
- Valid and start in the same cycle: both the write and the read occur. The read returns the pre-write contents, so there is no bypass.
- Unwritten entries read as 0.

## Timing
- Reset, when RST_n=1 is sampled at a clock edge:
  - all mem entries, wptr, rcnt and transpose_out become 0.
  - Reset takes priority over valid and start.
- Write latency: data is readable from the cycle after the valid edge.
- Read latency: 1 cycle. The element for the k-th cycle of start high appears after that edge.
- A 9-cycle start pulse yields the full Q^T, one element per cycle.
- Holding start beyond 9 cycles repeats the sequence from element 0.
- Reset mid-stream clears the stream immediately. The next start begins at element 0 on an empty (all-zero) matrix.

## Structure
- Shared package: the WORDLEN/FRACTION_WIDTH defaults and the constant transpose-index LUT T (9 x 4 bits).
- One natural sub-module, q_transpose_mem. It is the 9-entry register file with dual-write (pair) port, wrap logic and one combinational read port.
- The top level holds wptr, rcnt and the output register.

## Test plan
- Reset: assert RST_n for 1 cycle -> transpose_out=0. A following 9-cycle start streams nine zeros.
- Three pairs: pulse valid three times with (04cd,0333), (0666,0B33), (0400,0a66), then start for 9 cycles -> output 04cd, 0B33, 0000, 0333, 0400, 0000, 0666, 0a66, 0000.
- Full matrix: five pairs with values 1..10 (the last pair has wptr=8) -> mem=1..9, 10 dropped, wptr=0. Start for 9 cycles -> 1, 4, 7, 2, 5, 8, 3, 6, 9.
- Abort: start for 4 cycles, then low for 2, then high for 9 -> the second stream begins at T(0) and transpose_out=0 while start is low.
- Simultaneous events: valid at wptr=0 in the same cycle as the first start cycle -> the first output is the old mem[0]. The new value appears on the next stream.
- Reset mid-stream: RST_n=1 during the 5th read cycle -> output 0 and all mem cleared. The next stream yields all zeros.
